// File: rtl/mp3_ram_arb_pkg.sv
// Shared defaults and state encoding for the frame-RAM arbiter.
package mp3_ram_arb_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 1024;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 500;

  typedef enum logic [1:0] {RUN, DRAIN, FROZEN} arb_state_t;
endpackage

// File: rtl/mp3_rr_arb2.sv
// Two-way round-robin grant with a single pointer bit that favours the loser.
module mp3_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = rr_ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_o[0])      rr_ptr_d = 1'b1;
    else if (gnt_o[1]) rr_ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/mp3_frame_ram_arbiter.sv
// Two-master arbiter for the single-port frame RAM with freeze/drain handshake.
// Optional range check on accepted addresses: MP3_RAM_ARB_BOUNDS_CHECK_EN.
module mp3_frame_ram_arbiter #(
  parameter int ADDR_W = mp3_ram_arb_pkg::ADDR_W,
  parameter int DATA_W = mp3_ram_arb_pkg::DATA_W,
  parameter int BE_W   = mp3_ram_arb_pkg::BE_W,
  parameter int DEPTH  = mp3_ram_arb_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              freeze_req,
  output logic              freeze_ack,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              addr_err
);
  import mp3_ram_arb_pkg::*;

  arb_state_t state_q;
  logic [1:0] req, gnt;
  logic       run, any_gnt, wr_sel, oob, rd_acc;
  logic       rd_pend_q, rd_owner_q, rd_zero_q, freeze_ack_q, clken_q;

  assign req     = {m1_read | m1_write, m0_read | m0_write};
  assign run     = (state_q == RUN);
  assign any_gnt = |gnt;

  // No new grants are issued in the cycle freeze_req is first seen.
  mp3_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (reset_n),
    .req_i (req),
    .en_i  (run & ~freeze_req),
    .gnt_o (gnt)
  );

  assign m0_waitrequest = ~run | (req[0] & ~gnt[0]);
  assign m1_waitrequest = ~run | (req[1] & ~gnt[1]);

  assign ram_address    = gnt[1] ? m1_address    : m0_address;
  assign ram_writedata  = gnt[1] ? m1_writedata  : m0_writedata;
  assign ram_byteenable = gnt[1] ? m1_byteenable : m0_byteenable;
  assign wr_sel         = gnt[1] ? m1_write      : m0_write;

`ifdef MP3_RAM_ARB_BOUNDS_CHECK_EN
  logic addr_err_q;
  assign oob = any_gnt & ({1'b0, ram_address} >= (ADDR_W+1)'(DEPTH));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) addr_err_q <= 1'b0;
    else if (oob) addr_err_q <= 1'b1;
  end
  assign addr_err = addr_err_q;
`else
  assign oob      = 1'b0;
  assign addr_err = 1'b0;
`endif

  // Write wins over a simultaneous read from the same master.
  assign ram_chipselect = any_gnt & ~oob;
  assign ram_write      = any_gnt & wr_sel & ~oob;
  assign rd_acc         = any_gnt & ~wr_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      rd_pend_q  <= rd_acc;
      rd_owner_q <= gnt[1];
      rd_zero_q  <= oob;
    end
  end

  assign m0_readdatavalid = rd_pend_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q &  rd_owner_q;
  assign m0_readdata = (m0_readdatavalid & ~rd_zero_q) ? ram_readdata : '0;
  assign m1_readdata = (m1_readdatavalid & ~rd_zero_q) ? ram_readdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      freeze_ack_q <= 1'b0;
      clken_q      <= 1'b1;
    end else begin
      case (state_q)
        RUN: if (freeze_req) state_q <= DRAIN;
        DRAIN: if (!rd_pend_q) begin
          state_q      <= FROZEN;
          freeze_ack_q <= 1'b1;
          clken_q      <= 1'b0;
        end
        FROZEN: if (!freeze_req) begin
          state_q      <= RUN;
          freeze_ack_q <= 1'b0;
          clken_q      <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign freeze_ack = freeze_ack_q;
  assign ram_clken  = clken_q;
endmodule

// File: tb/tb_mp3_frame_ram_arbiter.sv
// Directed vector bench for the frame-RAM arbiter with a behavioural RAM.
module tb_mp3_frame_ram_arbiter;
  localparam int AW = 9;
  localparam int DW = 1024;
  localparam int BW = 128;
`ifdef MP3_RAM_ARB_BOUNDS_CHECK_EN
  localparam bit AE = 1'b1;
`else
  localparam bit AE = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [BW-1:0] m0_byteenable = '1, m1_byteenable = '1;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic freeze_req = 0, freeze_ack;
  logic [AW-1:0] ram_address;
  logic ram_chipselect, ram_write, ram_clken, addr_err;
  logic [DW-1:0] ram_writedata, ram_readdata;
  logic [BW-1:0] ram_byteenable;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mp3_frame_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .freeze_req(freeze_req), .freeze_ack(freeze_ack),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata),
    .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .addr_err(addr_err)
  );

  // Single-port RAM: address registered on the clock, q not re-registered.
  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] q = '0;
  assign ram_readdata = q;
  initial for (int i = 0; i < 512; i++) mem[i] = '0;

  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        w = mem[ram_address];
        for (int b = 0; b < BW; b++)
          if (ram_byteenable[b]) w[8*b +: 8] = ram_writedata[8*b +: 8];
        mem[ram_address] <= w;
      end else begin
        q <= mem[ram_address];
      end
    end
  end

  typedef struct {
    logic m0r, m0w; logic [AW-1:0] m0a; logic [7:0] m0b;
    logic m1r, m1w; logic [AW-1:0] m1a; logic [7:0] m1b;
    logic frz;
    logic e_m0wt, e_m1wt, e_cs, e_we; logic [AW-1:0] e_addr;
    logic e_m0v, e_m1v; logic [7:0] e_rdb;
    logic e_ack, e_clk, e_aerr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic m0r, m0w, logic [AW-1:0] m0a, logic [7:0] m0b,
                              logic m1r, m1w, logic [AW-1:0] m1a, logic [7:0] m1b,
                              logic frz, logic wt0, wt1, cs, we, logic [AW-1:0] ea,
                              logic v0, v1, logic [7:0] rdb, logic ack, ck, ae);
    vec_t v;
    v.m0r = m0r; v.m0w = m0w; v.m0a = m0a; v.m0b = m0b;
    v.m1r = m1r; v.m1w = m1w; v.m1a = m1a; v.m1b = m1b; v.frz = frz;
    v.e_m0wt = wt0; v.e_m1wt = wt1; v.e_cs = cs; v.e_we = we; v.e_addr = ea;
    v.e_m0v = v0; v.e_m1v = v1; v.e_rdb = rdb;
    v.e_ack = ack; v.e_clk = ck; v.e_aerr = ae;
    return v;
  endfunction

  task automatic chk(string nm, int row, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
    end
  endtask

  task automatic chkd(string nm, int row, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got low64 %h want low64 %h", nm, row, act[63:0], exp[63:0]);
    end
  endtask

  task automatic drive(vec_t v);
    m0_read = v.m0r; m0_write = v.m0w; m0_address = v.m0a; m0_writedata = {BW{v.m0b}};
    m1_read = v.m1r; m1_write = v.m1w; m1_address = v.m1a; m1_writedata = {BW{v.m1b}};
    freeze_req = v.frz;
  endtask

  task automatic check_vec(vec_t v, int row);
    logic [DW-1:0] e0, e1;
    e0 = v.e_m0v ? {BW{v.e_rdb}} : '0;
    e1 = v.e_m1v ? {BW{v.e_rdb}} : '0;
    chk("m0_waitrequest", row, 64'(m0_waitrequest), 64'(v.e_m0wt));
    chk("m1_waitrequest", row, 64'(m1_waitrequest), 64'(v.e_m1wt));
    chk("ram_chipselect", row, 64'(ram_chipselect), 64'(v.e_cs));
    chk("ram_write", row, 64'(ram_write), 64'(v.e_we));
    if (v.e_cs) chk("ram_address", row, 64'(ram_address), 64'(v.e_addr));
    chk("m0_readdatavalid", row, 64'(m0_readdatavalid), 64'(v.e_m0v));
    chk("m1_readdatavalid", row, 64'(m1_readdatavalid), 64'(v.e_m1v));
    chkd("m0_readdata", row, m0_readdata, e0);
    chkd("m1_readdata", row, m1_readdata, e1);
    chk("freeze_ack", row, 64'(freeze_ack), 64'(v.e_ack));
    chk("ram_clken", row, 64'(ram_clken), 64'(v.e_clk));
    chk("addr_err", row, 64'(addr_err), 64'(v.e_aerr));
  endtask

  vec_t idle;

  initial begin
    //          m0 r w addr byte  m1 r w addr byte frz  wt0 wt1 cs we addr v0 v1 rdb  ack clk aerr
    vq.push_back(mk(0,1,5,8'hA5, 0,0,0,8'h00, 0, 0,0,1,1,5,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 1,0,5,8'h00, 0, 0,0,1,0,5,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 0,1,6,8'h3C, 0, 0,0,1,1,6,   0,1,8'hA5, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 0,0,0,0,0,   0,0,8'h00, 0,1,0));
    // both masters reading continuously: grants alternate m0,m1,...
    vq.push_back(mk(1,0,5,8'h00, 1,0,6,8'h00, 0, 0,1,1,0,5,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(1,0,5,8'h00, 1,0,6,8'h00, 0, 1,0,1,0,6,   1,0,8'hA5, 0,1,0));
    vq.push_back(mk(1,0,5,8'h00, 1,0,6,8'h00, 0, 0,1,1,0,5,   0,1,8'h3C, 0,1,0));
    vq.push_back(mk(1,0,5,8'h00, 1,0,6,8'h00, 0, 1,0,1,0,6,   1,0,8'hA5, 0,1,0));
    vq.push_back(mk(1,0,5,8'h00, 1,0,6,8'h00, 0, 0,1,1,0,5,   0,1,8'h3C, 0,1,0));
    vq.push_back(mk(1,0,5,8'h00, 1,0,6,8'h00, 0, 1,0,1,0,6,   1,0,8'hA5, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 0,0,0,0,0,   0,1,8'h3C, 0,1,0));
    // read+write together: write only
    vq.push_back(mk(1,1,7,8'h77, 0,0,0,8'h00, 0, 0,0,1,1,7,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(1,0,7,8'h00, 0,0,0,8'h00, 0, 0,0,1,0,7,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 0,0,0,0,0,   1,0,8'h77, 0,1,0));
    // freeze with m1 read in flight
    vq.push_back(mk(0,0,0,8'h00, 1,0,6,8'h00, 0, 0,0,1,0,6,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(1,0,5,8'h00, 0,0,0,8'h00, 1, 1,0,0,0,0,   0,1,8'h3C, 0,1,0));
    vq.push_back(mk(1,0,5,8'h00, 0,0,0,8'h00, 1, 1,1,0,0,0,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(1,0,5,8'h00, 1,0,6,8'h00, 1, 1,1,0,0,0,   0,0,8'h00, 1,0,0));
    vq.push_back(mk(1,0,5,8'h00, 1,0,6,8'h00, 0, 1,1,0,0,0,   0,0,8'h00, 1,0,0));
    vq.push_back(mk(1,0,5,8'h00, 1,0,6,8'h00, 0, 0,1,1,0,5,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 0,0,0,0,0,   1,0,8'hA5, 0,1,0));
    // freeze dropped during DRAIN still passes through FROZEN once
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 1, 0,0,0,0,0,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 1,1,0,0,0,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 1,1,0,0,0,   0,0,8'h00, 1,0,0));
    vq.push_back(mk(0,0,0,8'h00, 1,0,5,8'h00, 0, 0,0,1,0,5,   0,0,8'h00, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 0,0,0,0,0,   0,1,8'hA5, 0,1,0));
    // out-of-range address 500
    vq.push_back(mk(1,0,500,8'h00, 0,0,0,8'h00, 0, 0,0,!AE,0,500, 0,0,8'h00, 0,1,0));
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 0,0,0,0,0,   1,0,8'h00, 0,1,AE));
    vq.push_back(mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 0,0,0,0,0,   0,0,8'h00, 0,1,AE));

    idle = mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 0,0,0,0,0, 0,0,8'h00, 0,1,0);

    // reset state
    @(negedge clk); #2;
    check_vec(idle, -1);
    @(negedge clk); reset_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #2 check_vec(vq[i], i);
    end

    // m0 read accepted (pointer now favours m1), then reset before its valid
    @(negedge clk);
    drive(mk(1,0,5,8'h00, 0,0,0,8'h00, 0, 0,0,0,0,0, 0,0,8'h00, 0,1,0));
    #2 chk("rst_seq_accept", 100, 64'(m0_waitrequest), 64'(0));
    @(negedge clk);
    drive(idle);
    reset_n = 1'b0;
    #2 check_vec(idle, 101);
    @(negedge clk);
    reset_n = 1'b1;
    drive(mk(1,0,5,8'h00, 1,0,6,8'h00, 0, 0,0,0,0,0, 0,0,8'h00, 0,1,0));
    #2;
    chk("rst_ptr_m0wt", 102, 64'(m0_waitrequest), 64'(0));
    chk("rst_ptr_m1wt", 102, 64'(m1_waitrequest), 64'(1));
    chk("rst_ptr_addr", 102, 64'(ram_address), 64'(5));
    @(negedge clk);
    drive(idle);
    #2;
    chk("post_rst_v0", 103, 64'(m0_readdatavalid), 64'(1));
    chkd("post_rst_d0", 103, m0_readdata, {BW{8'hA5}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
